// File: rtl/cc1200_spi_arbiter.sv
// cc1200_spi_arbiter: two-requester CC1200 single-register SPI master.
// Arbitrates req0/req1, then runs one CS_n-framed transaction per grant:
// CHIP_RDYn wait, header, optional extended-address byte, data byte.
// Optional build macro CC1200_ARB_FIXED_PRIO_EN: requester 0 always wins a
// simultaneous request (round-robin when undefined).
module cc1200_spi_arbiter #(
  parameter int CLK_DIV  = 4,
  parameter int RDY_TO   = 1023,
  parameter int CS_SETUP = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_status,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        CS_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CS_LO, S_WAIT_RDY, S_SHIFT, S_CS_HOLD, S_DONE, S_GAP
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] RDY_LAST   = 16'(RDY_TO - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);

  state_t      r_state;
  logic        r_gnt;
  logic [1:0]  r_req_ready;
  logic        r_ext;
  logic [23:0] r_tx;
  logic [23:0] r_rx;
  logic [15:0] r_cnt;
  logic [4:0]  r_bit;
  logic        r_cs_n;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_busy;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [7:0]  r_rsp_status;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_timeout;
  logic        r_miso_s1;
  logic        r_miso_s2;
`ifndef CC1200_ARB_FIXED_PRIO_EN
  logic        r_last_grant;
`endif

  logic        w_pick;
  logic        w_rw;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_ext;
  logic [7:0]  w_hdr;
  logic [7:0]  w_data;
  logic [23:0] w_tx;

  // Arbitration choice for the next grant (0 = req0, 1 = req1)
  always_comb begin
`ifdef CC1200_ARB_FIXED_PRIO_EN
    w_pick = ~req_valid[0];
`else
    if (&req_valid) w_pick = ~r_last_grant;
    else            w_pick = ~req_valid[0];
`endif
  end

  // Byte stream of the granted request, MSB-first and left-aligned
  always_comb begin
    w_rw    = r_gnt ? req_rw[1]         : req_rw[0];
    w_addr  = r_gnt ? req_addr[31:16]   : req_addr[15:0];
    w_wdata = r_gnt ? req_wdata[15:8]   : req_wdata[7:0];
    w_ext   = (w_addr[15:8] == 8'h2F);
    w_hdr   = {w_rw, 1'b0, (w_ext ? 6'h2F : w_addr[5:0])};
    w_data  = w_rw ? 8'h00 : w_wdata;
    w_tx    = w_ext ? {w_hdr, w_addr[7:0], w_data} : {w_hdr, w_data, 8'h00};
  end

  // Two-flop synchroniser for MISO (idles high)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_miso_s1 <= 1'b1;
      r_miso_s2 <= 1'b1;
    end else begin
      r_miso_s1 <= MISO;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Transaction FSM with registered pin and handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_gnt         <= 1'b0;
      r_req_ready   <= '0;
      r_ext         <= 1'b0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_cnt         <= '0;
      r_bit         <= '0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_busy        <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_status  <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
`ifndef CC1200_ARB_FIXED_PRIO_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_gnt       <= w_pick;
            r_req_ready <= w_pick ? 2'b10 : 2'b01;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_req_ready  <= '0;
`ifndef CC1200_ARB_FIXED_PRIO_EN
          r_last_grant <= r_gnt;
`endif
          r_ext        <= w_ext;
          r_tx         <= w_tx;
          r_rx         <= '0;
          r_busy       <= 1'b1;
          r_cs_n       <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_CS_LO;
        end
        S_CS_LO: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_RDY;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT_RDY: begin
          if (!r_miso_s2) begin
            r_mosi  <= r_tx[23];
            r_tx    <= {r_tx[22:0], 1'b0};
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end else if (r_cnt == RDY_LAST) begin
            r_cs_n        <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_gnt;
            r_rsp_status  <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              r_rx   <= {r_rx[22:0], r_miso_s2};
            end else begin
              r_sclk <= 1'b0;
              // Next MOSI bit is launched on the falling edge, i.e. a half-period ahead of its rising edge
              if (r_bit == (r_ext ? 5'd23 : 5'd15)) begin
                r_state <= S_CS_HOLD;
              end else begin
                r_bit  <= r_bit + 5'd1;
                r_mosi <= r_tx[23];
                r_tx   <= {r_tx[22:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CS_HOLD: begin
          if (r_cnt == DIV_LAST) begin
            r_cs_n        <= 1'b1;
            r_mosi        <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_gnt;
            r_rsp_status  <= r_ext ? r_rx[23:16] : r_rx[15:8];
            r_rsp_rdata   <= r_rx[7:0];
            r_rsp_timeout <= 1'b0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_rsp_valid <= 1'b0;
          r_cnt       <= '0;
          r_state     <= S_GAP;
        end
        S_GAP: begin
          if (r_cnt == DIV_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_status  = r_rsp_status;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = r_busy;
  assign SCLK        = r_sclk;
  assign MOSI        = r_mosi;
  assign CS_n        = r_cs_n;

endmodule
